// File: rtl/seq_divider_if.sv
// Operand/result bundle shared by a requester and the sequential divider.
// Latency: none, plain wires grouped for port hookup.
// Backpressure: none; start is only honoured by the divider while it is idle.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  // Requester side: drives operands and start, observes results.
  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock; signed mode via SEQ_DIVIDER_SIGNED_DIV_EN.
// Latency: done pulses in the cycle after edge start+WIDTH; divide-by-zero finishes the cycle after start.
// Backpressure: start is sampled only in IDLE; requests during RUN/DONE are dropped, never queued.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  // Partial remainder is one bit wider than the operands so a full-range
  // divisor cannot overflow the shifted value.
  logic [WIDTH:0]   a, a_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic [WIDTH-1:0] m, m_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] quo, quo_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;
  logic             dbz, dbz_nxt;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   a_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] dd_load;
  logic [WIDTH-1:0] dv_load;

`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
  // Sign of the final quotient / remainder, captured at load.
  logic qneg, qneg_nxt;
  logic rneg, rneg_nxt;
`endif

  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;
  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);

  // One restoring step: shift, trial subtract, keep or restore, plus final sign fix-up.
  always_comb begin
    shifted = {1'b0, a, q[WIDTH-1]};
    diff    = shifted - {2'b00, m};
    if (diff[WIDTH+1]) begin
      a_step = shifted[WIDTH:0];
      q_step = {q[WIDTH-2:0], 1'b0};
    end else begin
      a_step = diff[WIDTH:0];
      q_step = {q[WIDTH-2:0], 1'b1};
    end
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    q_fix   = qneg ? -q_step : q_step;
    r_fix   = rneg ? -a_step[WIDTH-1:0] : a_step[WIDTH-1:0];
    // Magnitudes; the most-negative value maps to 2^(WIDTH-1), which fits unsigned.
    dd_load = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    dv_load = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
`else
    q_fix   = q_step;
    r_fix   = a_step[WIDTH-1:0];
    dd_load = bus.dividend;
    dv_load = bus.divisor;
`endif
  end

  // Next-state and datapath update for IDLE -> RUN -> DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    q_nxt     = q;
    m_nxt     = m;
    cnt_nxt   = cnt;
    quo_nxt   = quo;
    rem_nxt   = rem;
    dbz_nxt   = dbz;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    qneg_nxt  = qneg;
    rneg_nxt  = rneg;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_nxt = DONE;
            quo_nxt   = '1;
            rem_nxt   = bus.dividend;
            dbz_nxt   = 1'b1;
          end else begin
            state_nxt = RUN;
            a_nxt     = '0;
            q_nxt     = dd_load;
            m_nxt     = dv_load;
            cnt_nxt   = CW'(WIDTH);
            dbz_nxt   = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
            qneg_nxt  = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            rneg_nxt  = bus.dividend[WIDTH-1];
`endif
          end
        end
      end
      RUN: begin
        a_nxt   = a_step;
        q_nxt   = q_step;
        cnt_nxt = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state_nxt = DONE;
          quo_nxt   = q_fix;
          rem_nxt   = r_fix;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath and result registers; reset clears everything, aborting any division.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a    <= '0;
      q    <= '0;
      m    <= '0;
      cnt  <= '0;
      quo  <= '0;
      rem  <= '0;
      dbz  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
      qneg <= 1'b0;
      rneg <= 1'b0;
`endif
    end else begin
      a    <= a_nxt;
      q    <= q_nxt;
      m    <= m_nxt;
      cnt  <= cnt_nxt;
      quo  <= quo_nxt;
      rem  <= rem_nxt;
      dbz  <= dbz_nxt;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
      qneg <= qneg_nxt;
      rneg <= rneg_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands.
// Expected results come from plain arithmetic on the operands.
// Works for both the unsigned and the SEQ_DIVIDER_SIGNED_DIV_EN builds.
module tb_seq_divider;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] last_q = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer division with truncation toward zero.
  function automatic void model(input logic [W-1:0] dd, input logic [W-1:0] dv,
                                output logic [W-1:0] eq, output logic [W-1:0] er,
                                output logic ez);
    if (dv == '0) begin
      eq = '1;
      er = dd;
      ez = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
      int sdd;
      int sdv;
      sdd = $signed(dd);
      sdv = $signed(dv);
      eq  = W'(sdd / sdv);
      er  = W'(sdd % sdv);
`else
      eq  = dd / dv;
      er  = dd % dv;
`endif
      ez  = 1'b0;
    end
  endfunction

  task automatic do_div(input logic [W-1:0] dd, input logic [W-1:0] dv, input string tag);
    logic [W-1:0] eq, er;
    logic ez;
    int n, nb;
    model(dd, dv, eq, er, ez);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dd;
    bus.divisor  = dv;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    n  = 0;
    nb = 0;
    if (dv != '0) chk({tag, "_hold_q"}, 32'(bus.quotient), 32'(last_q));
    while (!bus.done && n < 4 * W) begin
      if (bus.busy) nb++;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_done"},    32'(bus.done), 32'd1);
    chk({tag, "_latency"}, n,  (dv == '0) ? 0 : W);
    chk({tag, "_busycnt"}, nb, (dv == '0) ? 0 : W);
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_q"},   32'(bus.quotient),    32'(eq));
    chk({tag, "_r"},   32'(bus.remainder),   32'(er));
    chk({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(ez));
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    last_q = eq;
  endtask

  initial begin
    logic [W-1:0] eq, er;
    logic ez;
    int n, npulse;
    logic [W-1:0] got_q, got_r;

    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q",    32'(bus.quotient),    32'd0);
    chk("rst_r",    32'(bus.remainder),   32'd0);
    chk("rst_busy", 32'(bus.busy),        32'd0);
    chk("rst_done", 32'(bus.done),        32'd0);
    chk("rst_dbz",  32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    do_div(8'd200, 8'd7,   "d200_7");
    do_div(8'd255, 8'd255, "d255_255");
    do_div(8'd255, 8'd1,   "d255_1");
    do_div(8'd5,   8'd9,   "d5_9");
    do_div(8'd0,   8'd17,  "d0_17");
    do_div(8'd13,  8'd0,   "d13_0");
    do_div(8'd10,  8'd3,   "d10_3");

    // start pulses and operand changes during RUN must be ignored
    model(8'd100, 8'd3, eq, er, ez);
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0; npulse = 0; got_q = '0; got_r = '0;
    while (n < W + 6) begin
      if (n == 2) begin bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd5; end
      if (n == 4) begin bus.start = 1'b0; bus.dividend = 8'd77; bus.divisor = 8'd0; end
      if (bus.done) begin
        npulse++;
        got_q = bus.quotient;
        got_r = bus.remainder;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("ign_pulses", npulse, 1);
    chk("ign_q", 32'(got_q), 32'(eq));
    chk("ign_r", 32'(got_r), 32'(er));
    last_q = eq;

    // reset in the middle of a division
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_q",    32'(bus.quotient),    32'd0);
    chk("abort_r",    32'(bus.remainder),   32'd0);
    chk("abort_busy", 32'(bus.busy),        32'd0);
    chk("abort_done", 32'(bus.done),        32'd0);
    chk("abort_dbz",  32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    npulse = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) npulse++;
    end
    chk("abort_quiet", npulse, 0);
    last_q = '0;
    do_div(8'd9, 8'd2, "d9_2");

`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    do_div(8'h9C, 8'd7,  "s_m100_7");
    chk("s_m100_7_lit_q", 32'(bus.quotient),  32'h0F2);
    chk("s_m100_7_lit_r", 32'(bus.remainder), 32'h0FE);
    do_div(8'd100, 8'hF9, "s_100_m7");
    do_div(8'h80,  8'hFF, "s_m128_m1");
    chk("s_m128_m1_lit_q", 32'(bus.quotient), 32'h080);
    do_div(8'hFB,  8'h00, "s_m5_0");
    do_div(8'h80,  8'h01, "s_m128_1");
    do_div(8'h81,  8'h80, "s_m127_m128");
`endif

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] rd, rv;
      rd = W'($urandom);
      rv = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      do_div(rd, rv, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential radix-2 restoring divider. It is the inverse datapath of the team's Booth multiplier.
- Produces one quotient bit per clock, with a start/done handshake.
- Sits next to booth_multiplier in the arithmetic unit, so a MUL/DIV pair shares operand buses.
- Default is unsigned; signed mode is compiled in via macro.

Parameters:
WIDTH, 8, operand/quotient/remainder width in bits (>=2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  dividend, captured on accepted start
divisor  input  WIDTH  divisor, captured on accepted start
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
busy  output  1  high while a division is in progress (RUN state)
done  output  1  one-cycle pulse, results valid
div_by_zero  output  1  registered flag, valid with done

Behaviour:
- Reset (reset=0, async, any state): state=IDLE; quotient, remainder, busy, done, div_by_zero = 0; internal A, Q, M and counter = 0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k, divisor != 0:
  - Load A=0 (WIDTH+1 bits), Q=dividend, M=divisor, cnt=WIDTH.
  - Go to RUN; busy=1 after edge k.
- IDLE, start=1 at edge k, divisor == 0:
  - Go directly to DONE.
  - quotient = all ones, remainder = dividend, div_by_zero=1.
  - done=1 after edge k.
- RUN, each edge:
  - Shift {A,Q} left by 1.
  - A = A - M.
  - If A is negative: Q[0]=0 and restore A = A + M; else Q[0]=1.
  - cnt = cnt - 1.
  - On the edge where cnt goes 1→0: quotient=Q, remainder=A[WIDTH-1:0], state=DONE, busy=0, done=1.
- Latency: done is high in the cycle following edge k+WIDTH (8 cycles after start for WIDTH=8).
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE with done=0.
- quotient, remainder and div_by_zero hold their values until the next accepted start.
- On an accepted start, div_by_zero clears (unless the new divisor is 0), and quotient/remainder keep their old values until the new done.
- start is ignored in RUN and DONE; no queueing.
- Operand inputs are only sampled on an accepted start; changes during RUN have no effect.
- Reset asserted mid-RUN aborts immediately; there is no done pulse and all outputs read 0.
- Boundaries:
  - dividend < divisor → quotient=0, remainder=dividend.
  - dividend=0 → quotient=0, remainder=0.
  - divisor=1 → quotient=dividend.
  - Full-range operands (255/255) must not overflow; A is WIDTH+1 bits.

Optional Feature:
- Macro SEQ_DIVIDER_SIGNED_DIV_EN.
- Defined: operands are two's complement.
  - Magnitudes are taken at load; the unsigned core runs unchanged.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend (truncation toward zero).
  - The sign correction is applied in the RUN→DONE edge; latency is unchanged.
  - Most-negative / -1 wraps: quotient = most-negative, remainder = 0, no flag.
  - Divide by zero: quotient = all ones (-1), remainder = dividend, div_by_zero=1.
- Undefined: purely unsigned behaviour as above; no sign logic is synthesized.

Test Plan:
- Reset, then start with 200/7 → after 8 cycles done=1 for one cycle, quotient=28, remainder=4, div_by_zero=0, busy high for exactly 8 cycles.
- 255/255, then 255/1, then 5/9 back-to-back → (1,0), (255,0), (0,5); each gives a single done pulse, and pulses stay 0 between runs.
- 13/0 → done in the cycle after start, quotient=8'hFF, remainder=13, div_by_zero=1; a following 10/3 clears the flag and gives (3,1).
- start 100/3, then pulse start with 50/5 and change the operand inputs during RUN → those changes have no effect, result = (33,1), one done pulse only.
- start 200/7, assert reset low at cycle 4 for 1 cycle → all outputs 0, no done; a new start 9/2 → (4,1).
- SIGNED_DIV_EN:
  - -100/7 → quotient 8'hF2 (-14), remainder 8'hFE (-2).
  - 100/-7 → (-14, 2).
  - -128/-1 → (8'h80, 0).
  - -5/0 → (8'hFF, 8'hFB), div_by_zero=1.
